// File: rtl/xbar_pkg.sv
// Shared command encodings and width helper for the req/ack crossbar.
package xbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  function automatic int clog2(input int value);
    clog2 = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      clog2++;
    end
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Per-slave round-robin arbiter with grant lock plus the FIFO of master IDs awaiting read data.
// Grant is combinational; a locked grant holds until ack so the slave sees a stable request.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int RESP_DEPTH = 4,
  localparam int ID_W  = clog2(N_MASTERS),
  localparam int PTR_W = clog2(RESP_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] cmd,
  input  logic                 ack,
  input  logic                 pop,
  output logic                 gnt_vld,
  output logic [ID_W-1:0]      gnt_id,
  output logic                 full,
  output logic                 empty,
  output logic [ID_W-1:0]      head_id
);

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      lock_id;
  logic                 lock_vld;
  logic                 lock_hit;
  logic [N_MASTERS-1:0] rot;
  logic [ID_W:0]        rr_sum;
  logic [ID_W-1:0]      rr_id;
  logic                 rr_vld;
  logic [ID_W-1:0]      mem [RESP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 xfer;
  logic                 push;
  logic                 do_pop;

  // rot[k] is the request of master (rr_ptr + k) mod N; lowest k wins.
  always_comb begin
    rot    = N_MASTERS'({req, req} >> rr_ptr);
    rr_vld = 1'b0;
    rr_sum = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rr_vld = 1'b1;
        rr_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      end
    end
    rr_id = (rr_sum >= (ID_W+1)'(N_MASTERS)) ? ID_W'(rr_sum - (ID_W+1)'(N_MASTERS))
                                             : ID_W'(rr_sum);
  end

  assign lock_hit = lock_vld && req[lock_id];
  assign gnt_vld  = lock_hit || rr_vld;
  assign gnt_id   = lock_hit ? lock_id : rr_id;
  assign xfer     = gnt_vld && ack;
  assign push     = xfer && (cmd[gnt_id] == CMD_READ);
  assign full     = (count == (PTR_W+1)'(RESP_DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign head_id  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (xfer) begin
        rr_ptr   <= (gnt_id == ID_W'(N_MASTERS - 1)) ? '0 : gnt_id + ID_W'(1);
        lock_vld <= 1'b0;
      end else begin
        // A requester that withdrew is not re-locked, so the lock drops one cycle later.
        lock_vld <= gnt_vld;
        lock_id  <= gnt_id;
      end
      if (push) begin
        mem[wr_ptr] <= gnt_id;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (!push && do_pop) count <= count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/crossbar_nxm.sv
// N-master x M-slave req/ack crossbar; requests and read responses pass combinationally (zero latency).
// A master is held off (no ack) while its slave is busy, the slave's pending-read FIFO is full, or it has reads pending at another slave.
module crossbar_nxm
  import xbar_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int N_SLAVES   = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 4,
  localparam int SEL_W = clog2(N_SLAVES),
  localparam int SA_W  = ADDR_W - SEL_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          master_req,
  input  logic [N_MASTERS-1:0]          master_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]   master_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   master_wdata,
  output logic [N_MASTERS-1:0]          master_ack,
  output logic [N_MASTERS-1:0]          master_resp,
  output logic [N_MASTERS*DATA_W-1:0]   master_rdata,
  output logic [N_SLAVES-1:0]           slave_req,
  output logic [N_SLAVES-1:0]           slave_cmd,
  output logic [N_SLAVES*SA_W-1:0]      slave_addr,
  output logic [N_SLAVES*DATA_W-1:0]    slave_wdata,
  input  logic [N_SLAVES-1:0]           slave_ack,
  input  logic [N_SLAVES-1:0]           slave_resp,
  input  logic [N_SLAVES*DATA_W-1:0]    slave_rdata
);

  localparam int ID_W  = clog2(N_MASTERS);
  localparam int CNT_W = clog2(N_SLAVES * RESP_DEPTH + 1);

  logic [SEL_W-1:0]     tgt      [N_MASTERS];
  logic [CNT_W-1:0]     pend_cnt [N_MASTERS];
  logic [SEL_W-1:0]     pend_tgt [N_MASTERS];
  logic [N_MASTERS-1:0] rd_acc;
  logic [N_MASTERS-1:0] rd_dec;
  logic [N_SLAVES-1:0]  gnt_vld;
  logic [N_SLAVES-1:0]  fifo_full;
  logic [N_SLAVES-1:0]  fifo_empty;
  logic [N_SLAVES-1:0]  pop;
  logic [ID_W-1:0]      gnt_id  [N_SLAVES];
  logic [ID_W-1:0]      head_id [N_SLAVES];

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      tgt[i] = master_addr[i*ADDR_W + SA_W +: SEL_W];
    end
  end

  assign pop = slave_resp & ~fifo_empty;

  for (genvar s = 0; s < N_SLAVES; s++) begin : g_slv
    logic [N_MASTERS-1:0] cand;

    // A read may take the last FIFO slot freed by a same-cycle response.
    always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
        cand[i] = master_req[i] && (tgt[i] == SEL_W'(s))
               && ((pend_cnt[i] == '0) || (pend_tgt[i] == SEL_W'(s)))
               && ((master_cmd[i] == CMD_WRITE) || !fifo_full[s] || pop[s]);
      end
    end

    xbar_rr_arbiter #(
      .N_MASTERS  (N_MASTERS),
      .RESP_DEPTH (RESP_DEPTH)
    ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (cand),
      .cmd     (master_cmd),
      .ack     (slave_ack[s]),
      .pop     (pop[s]),
      .gnt_vld (gnt_vld[s]),
      .gnt_id  (gnt_id[s]),
      .full    (fifo_full[s]),
      .empty   (fifo_empty[s]),
      .head_id (head_id[s])
    );
  end

  always_comb begin
    slave_req    = '0;
    slave_cmd    = '0;
    slave_addr   = '0;
    slave_wdata  = '0;
    master_ack   = '0;
    master_resp  = '0;
    master_rdata = '0;
    rd_acc       = '0;
    rd_dec       = '0;
    if (!rst) begin
      for (int s = 0; s < N_SLAVES; s++) begin
        if (gnt_vld[s]) begin
          slave_req[s] = 1'b1;
          slave_cmd[s] = master_cmd[gnt_id[s]];
          slave_addr[s*SA_W +: SA_W]      = master_addr[int'(gnt_id[s])*ADDR_W +: SA_W];
          slave_wdata[s*DATA_W +: DATA_W] = master_wdata[int'(gnt_id[s])*DATA_W +: DATA_W];
          if (slave_ack[s]) begin
            master_ack[gnt_id[s]] = 1'b1;
            if (master_cmd[gnt_id[s]] == CMD_READ) rd_acc[gnt_id[s]] = 1'b1;
          end
        end
        if (pop[s]) begin
          master_resp[head_id[s]] = 1'b1;
          rd_dec[head_id[s]]      = 1'b1;
          master_rdata[int'(head_id[s])*DATA_W +: DATA_W] = slave_rdata[s*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_MASTERS; i++) begin
      if (rst) begin
        pend_cnt[i] <= '0;
        pend_tgt[i] <= '0;
      end else begin
        if (rd_acc[i]) pend_tgt[i] <= tgt[i];
        if (rd_acc[i] && !rd_dec[i])      pend_cnt[i] <= pend_cnt[i] + CNT_W'(1);
        else if (!rd_acc[i] && rd_dec[i]) pend_cnt[i] <= pend_cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_crossbar_nxm.sv
// Bench for crossbar_nxm (2x2, 32-bit): directed scenarios with a response scoreboard.
module tb_crossbar_nxm;

  localparam int NM = 2, NS = 2, AW = 32, DW = 32, RD = 4, SAW = AW - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     master_req, master_cmd, master_ack, master_resp;
  logic [NM*AW-1:0]  master_addr;
  logic [NM*DW-1:0]  master_wdata, master_rdata;
  logic [NS-1:0]     slave_req, slave_cmd, slave_ack, slave_resp;
  logic [NS*SAW-1:0] slave_addr;
  logic [NS*DW-1:0]  slave_wdata, slave_rdata;

  int vectors = 0;
  int miscompares = 0;
  int          exp_id_q[$];
  logic [31:0] exp_dat_q[$];

  logic [1:0] lock_req_tab [6] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01};
  logic [1:0] lock_ack_tab [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
  int         lock_gnt_tab [6] = '{1, 1, 1, 1, 1, 0};

  crossbar_nxm #(
    .N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .master_req(master_req), .master_cmd(master_cmd), .master_addr(master_addr),
    .master_wdata(master_wdata), .master_ack(master_ack), .master_resp(master_resp),
    .master_rdata(master_rdata), .slave_req(slave_req), .slave_cmd(slave_cmd),
    .slave_addr(slave_addr), .slave_wdata(slave_wdata), .slave_ack(slave_ack),
    .slave_resp(slave_resp), .slave_rdata(slave_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic idle();
    master_req = '0; master_cmd = '0; master_addr = '0; master_wdata = '0;
    slave_ack = '0; slave_resp = '0; slave_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    master_req = 2'b11; master_cmd = 2'b11;
    master_addr = {32'h8000_0008, 32'h0000_0004};
    master_wdata = {32'hBBBB_0000, 32'hAAAA_0000};
    slave_ack = 2'b11; slave_resp = 2'b11; slave_rdata = {32'h1234_5678, 32'h9ABC_DEF0};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({master_ack, master_resp, master_rdata, slave_req, slave_cmd, slave_addr, slave_wdata} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: ack=%b resp=%b sreq=%b saddr=%h want all zero",
                 c, master_ack, master_resp, slave_req, slave_addr);
      end
      tick();
    end
    rst = 1'b0;
    slave_resp = '0;
    master_addr = {32'h8000_0008, 32'h8000_000C};
    slave_ack = 2'b10;
    @(negedge clk);
    vectors++;
    if (master_ack !== 2'b01 || slave_req !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_s1: ack=%b sreq=%b want ack=01 sreq=10", master_ack, slave_req);
    end
    tick();
    master_addr = {32'h0000_0008, 32'h0000_000C};
    slave_ack = 2'b01;
    @(negedge clk);
    vectors++;
    if (master_ack !== 2'b01 || slave_req !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_first_s0: ack=%b sreq=%b want ack=01 sreq=01", master_ack, slave_req);
    end
    tick();
    idle();
  endtask

  task automatic test_contention();
    int exp;
    logic [1:0]     exp_ack;
    logic [SAW-1:0] exp_addr;
    logic [31:0]    exp_wd;
    do_reset();
    master_req = 2'b11; master_cmd = 2'b11;
    master_addr = {32'h4000_5678, 32'h0000_1234};
    master_wdata = {32'h2222_0000, 32'h1111_0000};
    slave_ack = 2'b01;
    for (int c = 0; c < 6; c++) exp_id_q.push_back(c % 2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp = exp_id_q.pop_front();
      exp_ack = '0;
      exp_ack[exp] = 1'b1;
      exp_addr = (exp == 1) ? 31'h4000_5678 : 31'h0000_1234;
      exp_wd   = (exp == 1) ? 32'h2222_0000 : 32'h1111_0000;
      vectors++;
      if (master_ack !== exp_ack) begin
        miscompares++;
        $display("FAIL contention_grant cycle %0d: ack=%b want %b", c, master_ack, exp_ack);
      end
      vectors++;
      if (slave_addr[SAW-1:0] !== exp_addr || slave_wdata[DW-1:0] !== exp_wd) begin
        miscompares++;
        $display("FAIL contention_fwd cycle %0d: addr=%h wdata=%h want addr=%h wdata=%h",
                 c, slave_addr[SAW-1:0], slave_wdata[DW-1:0], exp_addr, exp_wd);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    int exp;
    logic [1:0]     exp_ack;
    logic [SAW-1:0] exp_addr;
    do_reset();
    master_cmd = 2'b11;
    master_addr = {32'h8000_0040, 32'h8000_0080};
    for (int c = 0; c < 6; c++) begin
      master_req = lock_req_tab[c];
      slave_ack  = lock_ack_tab[c];
      exp_id_q.push_back(lock_gnt_tab[c]);
      @(negedge clk);
      exp = exp_id_q.pop_front();
      exp_ack = '0;
      if (slave_ack[1]) exp_ack[exp] = 1'b1;
      exp_addr = (exp == 1) ? 31'h0000_0040 : 31'h0000_0080;
      vectors++;
      if (slave_req !== 2'b10 || slave_cmd[1] !== 1'b1 || slave_addr[2*SAW-1:SAW] !== exp_addr
          || master_ack !== exp_ack) begin
        miscompares++;
        $display("FAIL lock cycle %0d: sreq=%b addr=%h ack=%b want sreq=10 addr=%h ack=%b",
                 c, slave_req, slave_addr[2*SAW-1:SAW], master_ack, exp_addr, exp_ack);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_read_routing();
    int          eid;
    logic [31:0] edat;
    do_reset();
    master_req = 2'b11; master_cmd = 2'b00;
    master_addr = {32'h8000_0020, 32'h0000_0010};
    slave_ack = 2'b11;
    @(negedge clk);
    vectors++;
    if (master_ack !== 2'b11 || slave_req !== 2'b11 || slave_cmd !== 2'b00
        || slave_addr !== {31'h0000_0020, 31'h0000_0010}) begin
      miscompares++;
      $display("FAIL rd_issue: ack=%b sreq=%b scmd=%b saddr=%h want 11 11 00 {20,10}",
               master_ack, slave_req, slave_cmd, slave_addr);
    end
    tick();
    idle();
    @(negedge clk);
    vectors++;
    if (master_resp !== 2'b00) begin
      miscompares++;
      $display("FAIL rd_early_resp: resp=%b want 00", master_resp);
    end
    tick();
    slave_resp = 2'b11;
    slave_rdata = {32'h5A5A_0002, 32'hA5A5_0001};
    exp_id_q.push_back(0); exp_dat_q.push_back(32'hA5A5_0001);
    exp_id_q.push_back(1); exp_dat_q.push_back(32'h5A5A_0002);
    @(negedge clk);
    for (int i = 0; i < NM; i++) begin
      if (master_resp[i]) begin
        vectors++;
        if (exp_id_q.size() == 0) begin
          miscompares++;
          $display("FAIL rd_route: unexpected resp at master %0d", i);
        end else begin
          eid  = exp_id_q.pop_front();
          edat = exp_dat_q.pop_front();
          if (eid != i || master_rdata[i*DW +: DW] !== edat) begin
            miscompares++;
            $display("FAIL rd_route: master %0d data=%h want master %0d data=%h",
                     i, master_rdata[i*DW +: DW], eid, edat);
          end
        end
      end
    end
    vectors++;
    if (exp_id_q.size() != 0) begin
      miscompares++;
      $display("FAIL rd_route_missing: %0d responses outstanding, want 0", exp_id_q.size());
      exp_id_q.delete(); exp_dat_q.delete();
    end
    tick();
    idle();
  endtask

  task automatic test_fifo_full();
    logic [31:0] edat;
    do_reset();
    master_req = 2'b01; master_cmd = 2'b00; slave_ack = 2'b01;
    for (int k = 0; k < 5; k++) begin
      master_addr[31:0] = 32'h0000_0100 + 32'(4 * k);
      @(negedge clk);
      vectors++;
      if (master_ack !== ((k < 4) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL fifo_fill read %0d: ack=%b want %b", k, master_ack, (k < 4) ? 2'b01 : 2'b00);
      end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 1) master_addr[31:0] = 32'h0000_0114;
      if (k >= 2) master_req = 2'b00;
      slave_resp = (k == 1) ? 2'b00 : 2'b01;
      slave_rdata[31:0] = 32'hD000_0000 + 32'(k);
      if (k != 1 && k < 6) begin
        exp_id_q.push_back(0);
        exp_dat_q.push_back(32'hD000_0000 + 32'(k));
      end
      @(negedge clk);
      if (k <= 1) begin
        vectors++;
        if (master_ack !== ((k == 0) ? 2'b01 : 2'b00)) begin
          miscompares++;
          $display("FAIL fifo_full_ack step %0d: ack=%b want %b", k, master_ack, (k == 0) ? 2'b01 : 2'b00);
        end
      end
      if (k != 1) begin
        vectors++;
        if (master_resp !== 2'b01 || exp_id_q.size() == 0) begin
          miscompares++;
          $display("FAIL fifo_resp step %0d: resp=%b want 01", k, master_resp);
        end else begin
          void'(exp_id_q.pop_front());
          edat = exp_dat_q.pop_front();
          if (master_rdata[DW-1:0] !== edat) begin
            miscompares++;
            $display("FAIL fifo_resp_data step %0d: data=%h want %h", k, master_rdata[DW-1:0], edat);
          end
        end
      end
      tick();
    end
    slave_resp = 2'b01;
    slave_rdata[31:0] = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (master_resp !== 2'b00) begin
      miscompares++;
      $display("FAIL fifo_empty_resp: resp=%b want 00", master_resp);
    end
    exp_id_q.delete(); exp_dat_q.delete();
    tick();
    idle();
  endtask

  task automatic test_target_block();
    do_reset();
    master_req = 2'b01; master_cmd = 2'b00;
    master_addr[31:0] = 32'h0000_0200; slave_ack = 2'b01;
    @(negedge clk);
    vectors++;
    if (master_ack !== 2'b01) begin
      miscompares++;
      $display("FAIL blk_issue: ack=%b want 01", master_ack);
    end
    tick();
    master_cmd = 2'b01;
    master_addr[31:0] = 32'h8000_0300; master_wdata[31:0] = 32'h0BAD_F00D;
    slave_ack = 2'b11; slave_resp = 2'b10; slave_rdata[63:32] = 32'hCAFE_0000;
    @(negedge clk);
    vectors++;
    if (master_ack !== 2'b00 || slave_req !== 2'b00 || master_resp !== 2'b00) begin
      miscompares++;
      $display("FAIL blk_hold: ack=%b sreq=%b resp=%b want 00 00 00", master_ack, slave_req, master_resp);
    end
    tick();
    slave_resp = 2'b00;
    @(negedge clk);
    vectors++;
    if (master_ack !== 2'b00) begin
      miscompares++;
      $display("FAIL blk_hold2: ack=%b want 00", master_ack);
    end
    tick();
    slave_resp = 2'b01; slave_rdata[31:0] = 32'hBEEF_0001;
    exp_id_q.push_back(0); exp_dat_q.push_back(32'hBEEF_0001);
    @(negedge clk);
    vectors++;
    if (master_resp !== 2'b01 || master_rdata[DW-1:0] !== exp_dat_q[0] || master_ack !== 2'b00) begin
      miscompares++;
      $display("FAIL blk_resp: resp=%b data=%h ack=%b want 01 %h 00",
               master_resp, master_rdata[DW-1:0], master_ack, exp_dat_q[0]);
    end
    exp_id_q.delete(); exp_dat_q.delete();
    tick();
    slave_resp = 2'b00;
    @(negedge clk);
    vectors++;
    if (master_ack !== 2'b01 || slave_req !== 2'b10 || slave_addr[2*SAW-1:SAW] !== 31'h0000_0300) begin
      miscompares++;
      $display("FAIL blk_release: ack=%b sreq=%b addr=%h want 01 10 300",
               master_ack, slave_req, slave_addr[2*SAW-1:SAW]);
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_contention();
    test_lock();
    test_read_routing();
    test_fifo_full();
    test_target_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
